// File: rtl/spi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// spi_mem_arbiter
//
// Shares one single-port SRAM between the SPI slave memory port and the CNN
// engine. It also decodes a 16-word CSR window at the top of SPI address space
// that holds the CNN start, status and cycle-count registers.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   spi_*         SPI slave memory port. spi_mem_en is a 1-cycle strobe that is
//                 qualified by spi_wr_en / spi_rd_en. spi_rd_data is
//                 combinational and valid in the strobe cycle.
//   cnn_*         CNN memory port (req/gnt), plus the cnn_start / cnn_done
//                 pulses to and from the CNN core.
//   mem_*         SRAM port. Writes happen on posedge clk; reads are
//                 asynchronous.
//   dbg_state     current control FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: the CNN holds cnn_req, with cnn_we/cnn_addr/cnn_wdata stable,
// until it sees cnn_gnt high. The SRAM access happens in the cycle where
// cnn_req and cnn_gnt are both high. For a read, cnn_rvalid pulses on the
// next cycle, and cnn_rdata keeps that value until the next granted read.
// SPI SRAM accesses win outright for their cycle. CSR accesses leave the
// SRAM free for the CNN.
// -----------------------------------------------------------------------------
module spi_mem_arbiter #(
   parameter int              DW       = 16,
   parameter int              AW       = 15,
   parameter logic [AW-1:0]   CSR_BASE = 15'h7FF0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          spi_mem_en,
   input  logic          spi_wr_en,
   input  logic          spi_rd_en,
   input  logic [DW-1:0] spi_addr,
   input  logic [DW-1:0] spi_wr_data,
   output logic [DW-1:0] spi_rd_data,
   input  logic          cnn_req,
   input  logic          cnn_we,
   input  logic [AW-1:0] cnn_addr,
   input  logic [DW-1:0] cnn_wdata,
   output logic          cnn_gnt,
   output logic          cnn_rvalid,
   output logic [DW-1:0] cnn_rdata,
   output logic          cnn_start,
   input  logic          cnn_done,
   output logic          mem_ce,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          start_go;      // accept a start request this cycle
   logic          done_set;      // RUN finishes this cycle
   logic          busy;
   logic          cnt_en;
   logic          done_sticky;
   logic [DW-1:0] cycle_cnt;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic          spi_hit, csr_hit;
   logic [AW-1:0] csr_diff;
   logic [3:0]    csr_off;
   logic          start_wr;
   logic [DW-1:0] csr_rdata;

   // The W/R flag in spi_addr[DW-1] and the high bits of the window offset are
   // never used for decoding.
   logic          unused_bits;
   assign unused_bits = ^{spi_addr[DW-1:AW], csr_diff[AW-1:4]};

   assign spi_hit  = spi_mem_en & (spi_wr_en | spi_rd_en);
   assign csr_hit  = spi_hit & (spi_addr[AW-1:0] >= CSR_BASE);
   assign csr_diff = spi_addr[AW-1:0] - CSR_BASE;
   assign csr_off  = csr_diff[3:0];
   assign start_wr = csr_hit & spi_wr_en & (csr_off == 4'd0) & spi_wr_data[0];

   always_comb begin
      csr_rdata = '0;
      case (csr_off)
         4'd1:    csr_rdata = {{(DW-2){1'b0}}, done_sticky, busy};
         4'd2:    csr_rdata = cycle_cnt;
         default: csr_rdata = '0;   // CTRL reads as 0, as do the spare words
      endcase
   end

   // ---------------------------------------------------------------------------
   // SRAM arbitration. SPI SRAM hits win; otherwise a pending CNN request is
   // granted.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cnn_gnt   = 1'b0;
      if (spi_hit && !csr_hit) begin
         mem_ce    = 1'b1;
         mem_we    = spi_wr_en;
         mem_addr  = spi_addr[AW-1:0];
         mem_wdata = spi_wr_data;
      end else if (cnn_req) begin
         mem_ce    = 1'b1;
         mem_we    = cnn_we;
         mem_addr  = cnn_addr;
         mem_wdata = cnn_wdata;
         cnn_gnt   = 1'b1;
      end
   end

   always_comb begin
      spi_rd_data = '0;
      if (spi_hit) spi_rd_data = csr_hit ? csr_rdata : mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnn_rvalid <= 1'b0;
         cnn_rdata  <= '0;
      end else begin
         cnn_rvalid <= cnn_gnt & ~cnn_we;
         if (cnn_gnt && !cnn_we) cnn_rdata <= mem_rdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Control FSM: next state. In RUN, start writes are ignored, so when a start
   // and cnn_done arrive together, done takes effect and the start is dropped.
   always_comb begin
      state_nxt = state;
      start_go  = 1'b0;
      done_set  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start_wr) begin
               state_nxt = ST_RUN;
               start_go  = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnn_done) begin
               state_nxt = ST_DONE;
               done_set  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Control FSM: outputs. The counter does not increment in the cycle where
   // cnn_done arrives, which keeps the final count frozen at that point.
   always_comb begin
      busy      = (state == ST_RUN);
      cnt_en    = (state == ST_RUN) & ~cnn_done;
      dbg_state = state;
   end

   // Start pulse, sticky done flag and saturating cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnn_start   <= 1'b0;
         done_sticky <= 1'b0;
         cycle_cnt   <= '0;
      end else begin
         cnn_start <= start_go;
         if (start_go)      done_sticky <= 1'b0;
         else if (done_set) done_sticky <= 1'b1;
         if (start_go)
            cycle_cnt <= '0;
         else if (cnt_en && (cycle_cnt != {DW{1'b1}}))
            cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

endmodule
